// File: rtl/mc_pkg.sv
// mc_pkg: instruction encodings, FSM state encoding and ALU operations shared
// by the multicycle core and its register file.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_TRAP   = 3'd5;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  function automatic logic funct_legal(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: REG_N x DATA_W register file, two combinational read ports and
// one synchronous write port; index 0 and indices >= REG_N read 0, writes dropped.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [4:0]        i_ra,
  input  logic [4:0]        i_rb,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b,
  input  logic              i_we,
  input  logic [4:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd
);
  localparam int         AW      = $clog2(REG_N);
  localparam logic [5:0] REG_LIM = 6'(REG_N);

  logic [DATA_W-1:0] r_regs [REG_N];
  logic              w_ra_ok, w_rb_ok, w_wa_ok;

  assign w_ra_ok = (i_ra != 5'd0) && ({1'b0, i_ra} < REG_LIM);
  assign w_rb_ok = (i_rb != 5'd0) && ({1'b0, i_rb} < REG_LIM);
  assign w_wa_ok = (i_wa != 5'd0) && ({1'b0, i_wa} < REG_LIM);

  assign o_rd_a = w_ra_ok ? r_regs[i_ra[AW-1:0]] : '0;
  assign o_rd_b = w_rb_ok ? r_regs[i_rb[AW-1:0]] : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
    end else if (i_we && w_wa_ok) begin
      r_regs[i_wa[AW-1:0]] <= i_wd;
    end
  end

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/DECODE/EXEC/MEM/WB core for lw/sw/addi/beq/add/sub/and/or/slt
// over a req/ack memory port. Define MC_RETIRE_CNT_EN to build the retired-instruction counter.
module multicycle_core
  import mc_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                REG_N    = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              reset,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [DATA_W-1:0] o_pc,
  output logic              o_retire,
  output logic              o_trap,
  output logic [31:0]       o_retired_cnt
);
  // state  | meaning
  // FETCH  | read instruction at PC; on ack latch IR, PC += 4
  // DECODE | read rs/rt, latch branch target, reject illegal encodings
  // EXEC   | ALU / address compute; beq resolves and retires here
  // MEM    | lw read or sw write, held until ack
  // WB     | register write-back and retire
  // TRAP   | illegal instruction; idle until reset

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  state_t            r_state;
  logic [DATA_W-1:0] r_pc, r_a, r_b, r_target, r_alu, r_mdr;
  logic [31:0]       r_ir;

  logic [5:0]        w_op, w_fn;
  logic [4:0]        w_rs, w_rt, w_rd, w_wb_addr;
  logic [DATA_W-1:0] w_simm, w_rd_a, w_rd_b, w_opb, w_alu, w_wb_data;
  logic              w_legal, w_is_mem, w_wb_en;
  alu_op_e           w_alu_op;

  assign w_op   = r_ir[31:26];
  assign w_rs   = r_ir[25:21];
  assign w_rt   = r_ir[20:16];
  assign w_rd   = r_ir[15:11];
  assign w_fn   = r_ir[5:0];
  assign w_simm = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};

  assign w_legal  = (w_op == OP_RTYPE) ? funct_legal(w_fn)
                                       : (w_op inside {OP_LW, OP_SW, OP_ADDI, OP_BEQ});
  assign w_is_mem = (w_op == OP_LW) || (w_op == OP_SW);

  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_op == OP_RTYPE) begin
      case (w_fn)
        FN_SUB:  w_alu_op = ALU_SUB;
        FN_AND:  w_alu_op = ALU_AND;
        FN_OR:   w_alu_op = ALU_OR;
        FN_SLT:  w_alu_op = ALU_SLT;
        default: w_alu_op = ALU_ADD;
      endcase
    end
  end

  assign w_opb = (w_op == OP_RTYPE) ? r_b : w_simm;

  always_comb begin
    w_alu = r_a + w_opb;
    case (w_alu_op)
      ALU_SUB: w_alu = r_a - w_opb;
      ALU_AND: w_alu = r_a & w_opb;
      ALU_OR:  w_alu = r_a | w_opb;
      ALU_SLT: w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_opb))};
      default: w_alu = r_a + w_opb;
    endcase
  end

  assign w_wb_en   = (r_state == ST_WB);
  assign w_wb_addr = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_alu;

  mc_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_regfile (
    .i_clk   (i_clk),
    .i_reset (reset),
    .i_ra    (w_rs),
    .i_rb    (w_rt),
    .o_rd_a  (w_rd_a),
    .o_rd_b  (w_rd_b),
    .i_we    (w_wb_en),
    .i_wa    (w_wb_addr),
    .i_wd    (w_wb_data)
  );

  // Request fields come straight from registers that only move on ack, so they hold while waiting.
  assign o_mem_req   = !reset && ((r_state == ST_FETCH) || (r_state == ST_MEM));
  assign o_mem_we    = o_mem_req && (r_state == ST_MEM) && (w_op == OP_SW);
  assign o_mem_addr  = (r_state == ST_MEM) ? r_alu : r_pc;
  assign o_mem_wdata = r_b;
  assign o_pc        = reset ? RESET_PC : r_pc;
  assign o_trap      = !reset && (r_state == ST_TRAP);
  assign o_retire    = !reset && ((r_state == ST_WB)
                    || ((r_state == ST_EXEC) && (w_op == OP_BEQ))
                    || ((r_state == ST_MEM) && (w_op == OP_SW) && i_mem_ack));

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_target <= '0;
      r_alu    <= '0;
      r_mdr    <= '0;
    end else begin
      case (r_state)
        ST_FETCH: if (i_mem_ack) begin
          r_ir    <= i_mem_rdata[31:0];
          r_pc    <= r_pc + PC_STEP;
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_a      <= w_rd_a;
          r_b      <= w_rd_b;
          r_target <= r_pc + (w_simm << 2);
          r_state  <= w_legal ? ST_EXEC : ST_TRAP;
        end
        ST_EXEC: begin
          r_alu <= w_alu;
          if (w_op == OP_BEQ) begin
            if (r_a == r_b) r_pc <= r_target;
            r_state <= ST_FETCH;
          end else begin
            r_state <= w_is_mem ? ST_MEM : ST_WB;
          end
        end
        ST_MEM: if (i_mem_ack) begin
          r_mdr   <= i_mem_rdata;
          r_state <= (w_op == OP_SW) ? ST_FETCH : ST_WB;
        end
        ST_WB:   r_state <= ST_FETCH;
        default: r_state <= ST_TRAP;
      endcase
    end
  end

`ifdef MC_RETIRE_CNT_EN
  logic [31:0] r_retired_cnt;

  always_ff @(posedge i_clk) begin
    if (reset)         r_retired_cnt <= '0;
    else if (o_retire) r_retired_cnt <= r_retired_cnt + 32'd1;
  end

  assign o_retired_cnt = reset ? '0 : r_retired_cnt;
`else
  assign o_retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed programs on a 32-bit core (RESET_PC 0) and a 64-bit,
// 8-register core (RESET_PC 2^64-4), with a req/ack memory model of configurable wait.
module tb_multicycle_core;

  logic clk;
  logic rst;

  logic        a_req, a_we, a_ack, a_retire, a_trap;
  logic [31:0] a_addr, a_wdata, a_rdata, a_pc, a_cnt;
  logic        b_req, b_we, b_ack, b_retire, b_trap;
  logic [63:0] b_addr, b_wdata, b_rdata, b_pc;
  logic [31:0] b_cnt;

  logic [31:0] imem_a [16];
  logic [31:0] imem_b [16];
  int          wait_cfg;
  int          wait_left;
  logic        stray_ack;

  localparam logic [31:0] LOAD_VAL = 32'd32;
  localparam logic [31:0] JUNK     = 32'hFC00_0000;
`ifdef MC_RETIRE_CNT_EN
  localparam logic [63:0] EXP_CNT2 = 64'd2;
`else
  localparam logic [63:0] EXP_CNT2 = 64'd0;
`endif

  int n_vec;
  int n_miscmp;

  multicycle_core #(.DATA_W(32), .REG_N(32), .RESET_PC(32'd0)) u_dut_a (
    .i_clk(clk), .reset(rst),
    .o_mem_req(a_req), .o_mem_we(a_we), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata),
    .i_mem_rdata(a_rdata), .i_mem_ack(a_ack),
    .o_pc(a_pc), .o_retire(a_retire), .o_trap(a_trap), .o_retired_cnt(a_cnt)
  );

  multicycle_core #(.DATA_W(64), .REG_N(8), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_b (
    .i_clk(clk), .reset(rst),
    .o_mem_req(b_req), .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata),
    .i_mem_rdata(b_rdata), .i_mem_ack(b_ack),
    .o_pc(b_pc), .o_retire(b_retire), .o_trap(b_trap), .o_retired_cnt(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory A: waits wait_cfg cycles per request; read data is junk (illegal opcode) unless acked.
  assign a_ack   = stray_ack || (a_req && (wait_left == 0));
  assign a_rdata = !a_ack ? JUNK : ((a_addr[1:0] != 2'b00) ? LOAD_VAL : imem_a[a_addr[5:2]]);
  assign b_ack   = b_req;
  assign b_rdata = b_ack ? {32'h0, imem_b[b_addr[5:2]]} : {32'h0, JUNK};

  always @(posedge clk) begin
    if (rst || (a_req && a_ack)) wait_left <= wait_cfg;
    else if (a_req && wait_left > 0) wait_left <= wait_left - 1;
  end

  logic [63:0] fa[$], sa_addr[$], sa_data[$], fb[$], sb_addr[$], sb_data[$];
  int          ra_cyc[$];
  int          cyc, first_req, a_req_n, b_ret_n;
  logic        b_snap_done;
  logic [31:0] b_cnt_snap;

  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; first_req = -1; a_req_n = 0; b_ret_n = 0;
      b_snap_done = 1'b0; b_cnt_snap = 32'hFFFF_FFFF;
      fa.delete(); sa_addr.delete(); sa_data.delete(); ra_cyc.delete();
      fb.delete(); sb_addr.delete(); sb_data.delete();
    end else begin
      cyc++;
      if (a_req) begin
        a_req_n++;
        if (first_req < 0) first_req = cyc;
      end
      if (a_req && a_ack) begin
        if (a_we) begin
          sa_addr.push_back(64'(a_addr));
          sa_data.push_back(64'(a_wdata));
        end else if (a_addr[1:0] == 2'b00) begin
          fa.push_back(64'(a_addr));
        end
      end
      if (a_retire) ra_cyc.push_back(cyc);
      if (b_ret_n == 2 && !b_snap_done) begin
        b_cnt_snap  = b_cnt;
        b_snap_done = 1'b1;
      end
      if (b_req && b_ack) begin
        if (b_we) begin
          sb_addr.push_back(b_addr);
          sb_data.push_back(b_wdata);
        end else begin
          fb.push_back(b_addr);
        end
      end
      if (b_retire) b_ret_n++;
    end
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    check_vec("rst_req_a",  64'(a_req), 64'd0);
    check_vec("rst_req_b",  64'(b_req), 64'd0);
    check_vec("rst_ret_a",  64'(a_retire), 64'd0);
    check_vec("rst_trap_a", 64'(a_trap), 64'd0);
    check_vec("rst_trap_b", 64'(b_trap), 64'd0);
    check_vec("rst_cnt_a",  64'(a_cnt), 64'd0);
    check_vec("rst_pc_a",   64'(a_pc), 64'd0);
    check_vec("rst_pc_b",   b_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    rst = 1'b0;
    #1;
    check_vec("first_req_a",  64'(a_req), 64'd1);
    check_vec("first_addr_a", 64'(a_addr), 64'd0);
    check_vec("first_addr_b", b_addr, 64'hFFFF_FFFF_FFFF_FFFC);
  endtask

  initial begin
    n_vec = 0; n_miscmp = 0;
    rst = 1'b1; wait_cfg = 0; stray_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      imem_a[i] = 32'h1000_FFFF;
      imem_b[i] = 32'h1000_FFFF;
    end

    // Program A1: lw, addi, add, sw, sub, slt, stores, r0 write, beq not-taken, beq self-loop
    imem_a[0]  = 32'h8C04_0003;  // lw   $4,3($0)
    imem_a[1]  = 32'h2005_0040;  // addi $5,$0,64
    imem_a[2]  = 32'h00A4_3020;  // add  $6,$5,$4
    imem_a[3]  = 32'hAC06_0001;  // sw   $6,1($0)
    imem_a[4]  = 32'h0085_3822;  // sub  $7,$4,$5
    imem_a[5]  = 32'h00E4_402A;  // slt  $8,$7,$4
    imem_a[6]  = 32'hAC07_0002;  // sw   $7,2($0)
    imem_a[7]  = 32'hAC08_0004;  // sw   $8,4($0)
    imem_a[8]  = 32'h2000_0007;  // addi $0,$0,7
    imem_a[9]  = 32'hAC00_0005;  // sw   $0,5($0)
    imem_a[10] = 32'h1085_0003;  // beq  $4,$5,3
    imem_a[11] = 32'h1000_FFFF;  // beq  $0,$0,-1
    // Program B: starts at 2^64-4, so the second fetch wraps to 0
    imem_b[15] = 32'h2009_0005;  // addi $9,$0,5
    imem_b[0]  = 32'h0120_0820;  // add  $1,$9,$0
    imem_b[1]  = 32'hAC01_0000;  // sw   $1,0($0)
    imem_b[2]  = 32'h2002_FFFD;  // addi $2,$0,-3
    imem_b[3]  = 32'hAC02_0008;  // sw   $2,8($0)

    do_reset();
    tick(90);
    check_vec("lw_latency", (ra_cyc.size() > 0) ? 64'(ra_cyc[0] - first_req) : 64'hBAD, 64'd4);
    check_vec("addi_latency", (ra_cyc.size() > 1) ? 64'(ra_cyc[1] - ra_cyc[0]) : 64'hBAD, 64'd4);
    check_vec("sw_latency", (ra_cyc.size() > 3) ? 64'(ra_cyc[3] - ra_cyc[2]) : 64'hBAD, 64'd4);
    check_vec("beq_latency", (ra_cyc.size() > 11) ? 64'(ra_cyc[11] - ra_cyc[10]) : 64'hBAD, 64'd3);
    check_vec("st0_addr", (sa_addr.size() > 0) ? sa_addr[0] : 64'hBAD, 64'd1);
    check_vec("st0_add",  (sa_data.size() > 0) ? sa_data[0] : 64'hBAD, 64'd96);
    check_vec("st1_sub",  (sa_data.size() > 1) ? sa_data[1] : 64'hBAD, 64'hFFFF_FFE0);
    check_vec("st2_slt",  (sa_data.size() > 2) ? sa_data[2] : 64'hBAD, 64'd1);
    check_vec("st3_r0",   (sa_data.size() > 3) ? sa_data[3] : 64'hBAD, 64'd0);
    check_vec("st3_addr", (sa_addr.size() > 3) ? sa_addr[3] : 64'hBAD, 64'd5);
    check_vec("beq_nt_fetch", (fa.size() > 11) ? fa[11] : 64'hBAD, 64'd44);
    check_vec("beq_tk_fetch", (fa.size() > 12) ? fa[12] : 64'hBAD, 64'd44);
    check_vec("b_fetch0", (fb.size() > 0) ? fb[0] : 64'hBAD, 64'hFFFF_FFFF_FFFF_FFFC);
    check_vec("b_fetch_wrap", (fb.size() > 1) ? fb[1] : 64'hBAD, 64'd0);
    check_vec("b_reg9_dropped", (sb_data.size() > 0) ? sb_data[0] : 64'hBAD, 64'd0);
    check_vec("b_sext64_addr", (sb_addr.size() > 1) ? sb_addr[1] : 64'hBAD, 64'd8);
    check_vec("b_sext64_data", (sb_data.size() > 1) ? sb_data[1] : 64'hBAD, 64'hFFFF_FFFF_FFFF_FFFD);
    check_vec("b_retired_cnt", 64'(b_cnt_snap), EXP_CNT2);

    // Program A2: every request waits 3 cycles; junk on rdata until ack
    wait_cfg   = 3;
    imem_a[0]  = 32'h2001_0001;  // addi $1,$0,1
    imem_a[1]  = 32'hAC01_0000;  // sw   $1,0($0)
    imem_a[2]  = 32'h1000_FFFF;  // beq  $0,$0,-1 at PC 8
    do_reset();
    check_vec("dly_ack_c1", 64'(a_ack), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      tick(1);
      check_vec($sformatf("dly_req_c%0d", i), 64'(a_req), 64'd1);
      check_vec($sformatf("dly_addr_c%0d", i), 64'(a_addr), 64'd0);
    end
    check_vec("dly_ack_c4", 64'(a_ack), 64'd1);
    tick(1);
    check_vec("dly_req_drop", 64'(a_req), 64'd0);
    tick(60);
    check_vec("dly_st_addr", (sa_addr.size() > 0) ? sa_addr[0] : 64'hBAD, 64'd0);
    check_vec("dly_st_data", (sa_data.size() > 0) ? sa_data[0] : 64'hBAD, 64'd1);
    check_vec("dly_sw_latency", (ra_cyc.size() > 1) ? 64'(ra_cyc[1] - ra_cyc[0]) : 64'hBAD, 64'd10);
    check_vec("beq8_fetch", (fa.size() > 3) ? fa[3] : 64'hBAD, 64'd8);

    // Program A3: illegal opcode 0x3F, stray ack in TRAP, then illegal funct
    wait_cfg  = 0;
    imem_a[0] = 32'hFC00_0000;
    do_reset();
    tick(10);
    check_vec("trap_op",      64'(a_trap), 64'd1);
    check_vec("trap_pc",      64'(a_pc), 64'd4);
    check_vec("trap_nreq",    64'(a_req_n), 64'd1);
    stray_ack = 1'b1;
    tick(4);
    stray_ack = 1'b0;
    tick(1);
    check_vec("trap_stray_pc",   64'(a_pc), 64'd4);
    check_vec("trap_stray_nreq", 64'(a_req_n), 64'd1);
    check_vec("trap_sticky",     64'(a_trap), 64'd1);
    imem_a[0] = 32'h0000_0021;  // R-type funct 0x21
    do_reset();
    tick(10);
    check_vec("trap_funct", 64'(a_trap), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
